readout_rcv: RTL and testbench
==============================

READOUT_RCV -- requirements
Module: readout_rcv

Interface
REQ-001 TMR, default 0: when 1, the state register and channel counter SHALL be triplicated and majority-voted; the function is unchanged.
REQ-002 CLK  in  1  sole clock; all logic on rising edge.
REQ-003 RST_B  in  1  asynchronous, active-low reset.
REQ-004 PUSH  in  1  data word valid, one word per cycle high.
REQ-005 DIN  in  12  ADC word, qualified by PUSH.
REQ-006 ADO  in  4  Gray-coded channel address, qualified by PUSH.
REQ-007 D13IN  in  1  serial header bit, qualified by PUSH and aligned upstream.
REQ-008 D14IN  in  1  overlap bit, qualified by PUSH; low means overlap.
REQ-009 LASTWORD  in  1  end-of-event pulse; may coincide with PUSH or stand alone.
REQ-010 WR_FULL  in  1  downstream FIFO full.
REQ-011 CLR_ERR  in  1  synchronous clear of the sticky error flags.
REQ-012 DOUT  out  16  {channel binary[3:0], DIN[11:0]}.
REQ-013 DOUT_WE  out  1  downstream write strobe.
REQ-014 HDR_VLD  out  1  one-cycle pulse; the HDR_* outputs have updated.
REQ-015 HDR_L1P  out  8  assembled L1A pattern.
REQ-016 HDR_SCA  out  4  assembled SCA block number.
REQ-017 HDR_FLG  out  4  {ovlp, scafull, lct_phase, l1a_phase}.
REQ-018 EVT_DONE  out  1  one-cycle pulse at event completion.
REQ-019 EVT_NODATA  out  1  valid with EVT_DONE; the event had zero words.
REQ-020 SMPCNT  out  5  completed samples in the event; valid with EVT_DONE.
REQ-021 ERR_SEQ, ERR_OVF  out  1 each  sticky error flags.

Function
REQ-022 Gray decode: ch_bin[3] = ADO[3]; ch_bin[i] = ch_bin[i+1] XOR ADO[i].
REQ-023 Expected channel ch_exp:
- starts at 0;
- increments on each accepted PUSH;
- wraps 15 to 0, and the wrap increments the sample count, saturating at 31.
REQ-024 Channel mismatch (PUSH with ch_bin != ch_exp): set ERR_SEQ, store the word anyway, and set ch_exp to ch_bin+1.
REQ-025 Header assembly on PUSH:
- D13IN goes to header bit ch_bin;
- bits 0-7 form L1P;
- bits 8-11 form SCA;
- bit 12 is l1a_phase, bit 13 lct_phase, bit 14 scafull;
- bit 15 is expected 0, and a 1 there sets ERR_SEQ.
REQ-026 Overlap: ovlp = NOT D14IN, sampled at channel 0.
REQ-027 Header publish: on PUSH with ch_bin == 15, the HDR_* outputs update and HDR_VLD pulses on the next cycle.
REQ-028 Buffer: 4-entry FIFO of DOUT words.
- Write on PUSH.
- Read when non-empty and WR_FULL low; DOUT_WE is high in the same cycle as the read.
REQ-029 Latency: PUSH at cycle n into an empty buffer with WR_FULL low gives DOUT_WE at n+1.
REQ-030 Overflow: PUSH while the buffer holds 4 entries and no read occurs in that cycle drops the word and sets ERR_OVF; a same-cycle read and write while full is not an overflow.
REQ-031 States: IDLE (no words yet in the event), COLLECT (at least one word accepted), DRAIN (LASTWORD seen, buffer not yet empty).
REQ-032 IDLE transitions:
- PUSH goes to COLLECT;
- LASTWORD without PUSH stays in IDLE and gives EVT_DONE with EVT_NODATA=1 and SMPCNT=0 on the next cycle.
REQ-033 COLLECT to DRAIN on LASTWORD; a coincident PUSH belongs to the current event.
REQ-034 LASTWORD with ch_exp != 0 (partial sample) sets ERR_SEQ.
REQ-035 DRAIN to IDLE when the buffer is empty, with these same-cycle actions:
- pulse EVT_DONE with EVT_NODATA=0;
- drive SMPCNT;
- clear ch_exp and the sample count.
REQ-036 PUSH during DRAIN is accepted into the buffer and counted in the next event; FSM exit still waits for an empty buffer.
REQ-037 LASTWORD during DRAIN sets ERR_SEQ and is otherwise ignored.
REQ-038 CLR_ERR clears ERR_SEQ and ERR_OVF; an error event in the same cycle wins.

Reset
REQ-039 While RST_B is low, the following SHALL be 0:
- all outputs;
- the FSM (at IDLE);
- the buffer (empty);
- ch_exp and the sample count.
REQ-040 Reset mid-event discards buffered words and produces no EVT_DONE.

Verification
REQ-041 Nominal: 2 samples x 16 PUSHes, Gray ADO 0..15, D13 pattern giving L1P=0xA5, SCA=0x9, l1a_phase=1, then LASTWORD. Required response:
- 32 DOUT_WE;
- DOUT[15:12] = 0..15 twice;
- HDR_VLD twice, with HDR_L1P=0xA5 and HDR_SCA=0x9;
- EVT_DONE with SMPCNT=2.
REQ-042 NODATA: LASTWORD alone in IDLE -> EVT_DONE and EVT_NODATA=1 on the next cycle, SMPCNT=0, no DOUT_WE.
REQ-043 Backpressure: WR_FULL high, 6 consecutive PUSHes -> ERR_OVF=1 and 4 words retained; WR_FULL low -> 4 DOUT_WE, then EVT_DONE after LASTWORD.
REQ-044 Sequence error: ADO skips from channel 3 to 5 -> ERR_SEQ=1 and next expected channel 6; CLR_ERR -> ERR_SEQ=0.
REQ-045 Corner cases:
- PUSH and LASTWORD in the same cycle on channel 15 -> word included and SMPCNT counts that sample;
- RST_B low mid-DRAIN -> no EVT_DONE and DOUT_WE=0.

Source files
------------

// File: rtl/readout_rcv.sv
// Readout receiver: checks the Gray-coded channel sequence, assembles the serial header,
// buffers data words in a 4-deep FIFO and frames events for the downstream writer.
module readout_rcv #(
  parameter bit TMR = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_b,
  input  logic        i_push,
  input  logic [11:0] i_din,
  input  logic [3:0]  i_ado,
  input  logic        i_d13in,
  input  logic        i_d14in,
  input  logic        i_lastword,
  input  logic        i_wr_full,
  input  logic        i_clr_err,
  output logic [15:0] o_dout,
  output logic        o_dout_we,
  output logic        o_hdr_vld,
  output logic [7:0]  o_hdr_l1p,
  output logic [3:0]  o_hdr_sca,
  output logic [3:0]  o_hdr_flg,
  output logic        o_evt_done,
  output logic        o_evt_nodata,
  output logic [4:0]  o_smpcnt,
  output logic        o_err_seq,
  output logic        o_err_ovf
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  localparam int unsigned NCP = TMR ? 3 : 1;

  logic [1:0]  r_st [NCP];
  logic [3:0]  r_ch [NCP];
  logic [1:0]  w_st, w_st_nx;
  logic [3:0]  w_ch_exp, w_ch_exp_nx, w_ch_post, w_ch_bin;

  logic [4:0]  r_smp, r_smp_evt, w_smp_post, w_smp_nx;
  logic        r_pend, w_pend_nx;
  logic        w_lock, w_done, w_nodata, w_seq_err;

  logic [15:0] r_mem [4];
  logic [1:0]  r_wp, r_rp;
  logic [2:0]  r_cnt;
  logic        w_empty, w_full, w_rd, w_wr, w_ovf;

  logic [14:0] r_hdr;
  logic        r_ovlp;
  logic        r_hdr_vld, r_evt_done, r_evt_nodata, r_err_seq, r_err_ovf;
  logic [7:0]  r_l1p;
  logic [3:0]  r_sca, r_flg;
  logic [4:0]  r_smpcnt;

  // Majority vote when triplicated; the copies all load the same next value.
  if (TMR) begin : g_tmr
    assign w_st     = (r_st[0] & r_st[1]) | (r_st[1] & r_st[2]) | (r_st[0] & r_st[2]);
    assign w_ch_exp = (r_ch[0] & r_ch[1]) | (r_ch[1] & r_ch[2]) | (r_ch[0] & r_ch[2]);
  end else begin : g_single
    assign w_st     = r_st[0];
    assign w_ch_exp = r_ch[0];
  end

  assign w_ch_bin = {i_ado[3],
                     i_ado[3] ^ i_ado[2],
                     i_ado[3] ^ i_ado[2] ^ i_ado[1],
                     i_ado[3] ^ i_ado[2] ^ i_ado[1] ^ i_ado[0]};

  assign w_empty = (r_cnt == 3'd0);
  assign w_full  = (r_cnt == 3'd4);
  assign w_rd    = !w_empty && !i_wr_full;
  assign w_wr    = i_push && (!w_full || w_rd);
  assign w_ovf   = i_push && w_full && !w_rd;

  // Matched or not, the next expected channel always follows the received one.
  assign w_ch_post  = i_push ? w_ch_bin + 4'd1 : w_ch_exp;
  assign w_smp_post = (i_push && (w_ch_bin == 4'hf) && (r_smp != 5'd31)) ? r_smp + 5'd1 : r_smp;

  always_comb begin
    w_st_nx     = w_st;
    w_ch_exp_nx = w_ch_post;
    w_smp_nx    = w_smp_post;
    w_pend_nx   = r_pend;
    w_lock      = 1'b0;
    w_done      = 1'b0;
    w_nodata    = 1'b0;
    w_seq_err   = i_push && ((w_ch_bin != w_ch_exp) || ((w_ch_bin == 4'hf) && i_d13in));
    case (w_st)
      ST_IDLE, ST_COLLECT: begin
        if (i_lastword) begin
          if ((w_st == ST_IDLE) && !i_push) begin
            w_done   = 1'b1;
            w_nodata = 1'b1;
          end else begin
            // Close the event now so words pushed while draining start the next one.
            if (w_ch_post != 4'd0) w_seq_err = 1'b1;
            w_lock      = 1'b1;
            w_st_nx     = ST_DRAIN;
            w_pend_nx   = 1'b0;
            w_ch_exp_nx = 4'd0;
            w_smp_nx    = 5'd0;
          end
        end else if (i_push) begin
          w_st_nx = ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        if (i_lastword) w_seq_err = 1'b1;
        if (i_push) w_pend_nx = 1'b1;
        if (w_empty) begin
          w_done  = 1'b1;
          w_st_nx = (r_pend || i_push) ? ST_COLLECT : ST_IDLE;
        end
      end
      default: w_st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      for (int unsigned i = 0; i < NCP; i++) begin
        r_st[i] <= ST_IDLE;
        r_ch[i] <= 4'd0;
      end
      r_smp     <= 5'd0;
      r_smp_evt <= 5'd0;
      r_pend    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCP; i++) begin
        r_st[i] <= w_st_nx;
        r_ch[i] <= w_ch_exp_nx;
      end
      r_smp  <= w_smp_nx;
      r_pend <= w_pend_nx;
      if (w_lock) r_smp_evt <= w_smp_post;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 16'd0;
      r_wp  <= 2'd0;
      r_rp  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= {w_ch_bin, i_din};
        r_wp        <= r_wp + 2'd1;
      end
      if (w_rd) r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + {2'b00, w_wr} - {2'b00, w_rd};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_hdr     <= 15'd0;
      r_ovlp    <= 1'b0;
      r_hdr_vld <= 1'b0;
      r_l1p     <= 8'd0;
      r_sca     <= 4'd0;
      r_flg     <= 4'd0;
    end else begin
      r_hdr_vld <= 1'b0;
      if (i_push) begin
        for (int i = 0; i < 15; i++) begin
          if (w_ch_bin == 4'(i)) r_hdr[i] <= i_d13in;
        end
        if (w_ch_bin == 4'd0) r_ovlp <= ~i_d14in;
        if (w_ch_bin == 4'hf) begin
          r_hdr_vld <= 1'b1;
          r_l1p     <= r_hdr[7:0];
          r_sca     <= r_hdr[11:8];
          r_flg     <= {r_ovlp, r_hdr[14], r_hdr[13], r_hdr[12]};
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_evt_done   <= 1'b0;
      r_evt_nodata <= 1'b0;
      r_smpcnt     <= 5'd0;
      r_err_seq    <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_evt_done   <= w_done;
      r_evt_nodata <= w_done && w_nodata;
      if (w_done) r_smpcnt <= w_nodata ? 5'd0 : r_smp_evt;
      if (w_seq_err)      r_err_seq <= 1'b1;
      else if (i_clr_err) r_err_seq <= 1'b0;
      if (w_ovf)          r_err_ovf <= 1'b1;
      else if (i_clr_err) r_err_ovf <= 1'b0;
    end
  end

  assign o_dout       = r_mem[r_rp];
  assign o_dout_we    = w_rd;
  assign o_hdr_vld    = r_hdr_vld;
  assign o_hdr_l1p    = r_l1p;
  assign o_hdr_sca    = r_sca;
  assign o_hdr_flg    = r_flg;
  assign o_evt_done   = r_evt_done;
  assign o_evt_nodata = r_evt_nodata;
  assign o_smpcnt     = r_smpcnt;
  assign o_err_seq    = r_err_seq;
  assign o_err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_readout_rcv.sv
// Bench for readout_rcv: directed event scenarios, a queue-based reference model checked
// every cycle, and literal expectations after each scenario.
module tb_readout_rcv;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        push = 1'b0, d13 = 1'b0, d14 = 1'b1, lastword = 1'b0, wr_full = 1'b0;
  logic        clr_err = 1'b0;
  logic [11:0] din = 12'd0;
  logic [3:0]  ado = 4'd0;
  logic [15:0] dout;
  logic        dout_we, hdr_vld, evt_done, evt_nodata, err_seq, err_ovf;
  logic [7:0]  hdr_l1p;
  logic [3:0]  hdr_sca, hdr_flg;
  logic [4:0]  smpcnt;

  always #5 clk = ~clk;

  readout_rcv dut (
    .i_clk(clk), .i_rst_b(rst_b), .i_push(push), .i_din(din), .i_ado(ado),
    .i_d13in(d13), .i_d14in(d14), .i_lastword(lastword), .i_wr_full(wr_full),
    .i_clr_err(clr_err), .o_dout(dout), .o_dout_we(dout_we), .o_hdr_vld(hdr_vld),
    .o_hdr_l1p(hdr_l1p), .o_hdr_sca(hdr_sca), .o_hdr_flg(hdr_flg), .o_evt_done(evt_done),
    .o_evt_nodata(evt_nodata), .o_smpcnt(smpcnt), .o_err_seq(err_seq), .o_err_ovf(err_ovf)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(input logic [3:0] g);
    int b;
    int acc;
    b = 0;
    acc = 0;
    for (int i = 3; i >= 0; i--) begin
      acc = acc ^ int'(g[i]);
      b = b + (acc << i);
    end
    return b;
  endfunction

  // Reference model state
  logic [15:0] mq[$];
  int          m_exp_ch = 0, m_smp = 0, m_evt_smp = 0, m_smp_out = 0;
  int          m_phase = 0;  // 0: no words yet, 1: words seen, 2: closed, emptying
  bit          m_dpush = 0, m_done = 0, m_nodata = 0, m_hvld = 0, m_ovlp = 0;
  bit          m_eseq = 0, m_eovf = 0;
  logic [14:0] m_hdr = '0;
  int          m_l1p = 0, m_sca = 0, m_flg = 0;

  // Tallies for scenario-level literal checks
  int c_we = 0, c_hvld = 0, c_done = 0, last_smp = 0, last_nodata = 0;

  always @(negedge clk) begin
    bit rd, seq, ovf;
    int pre, ch;
    logic [3:0] chb;
    if (!rst_b) begin
      chk("reset_outputs_zero", int'(|{dout, dout_we, hdr_vld, hdr_l1p, hdr_sca, hdr_flg,
          evt_done, evt_nodata, smpcnt, err_seq, err_ovf}), 0);
      mq.delete();
      m_exp_ch = 0; m_smp = 0; m_evt_smp = 0; m_smp_out = 0; m_phase = 0; m_dpush = 0;
      m_done = 0; m_nodata = 0; m_hvld = 0; m_ovlp = 0; m_eseq = 0; m_eovf = 0; m_hdr = '0;
      m_l1p = 0; m_sca = 0; m_flg = 0;
    end else begin
      rd = (mq.size() > 0) && !wr_full;
      chk("dout_we", int'(dout_we), int'(rd));
      if (rd && dout_we) chk("dout", int'(dout), int'(mq[0]));
      chk("evt_done", int'(evt_done), int'(m_done));
      if (m_done) begin
        chk("evt_nodata", int'(evt_nodata), int'(m_nodata));
        chk("smpcnt", int'(smpcnt), m_smp_out);
      end
      chk("hdr_vld", int'(hdr_vld), int'(m_hvld));
      if (m_hvld) begin
        chk("hdr_l1p", int'(hdr_l1p), m_l1p);
        chk("hdr_sca", int'(hdr_sca), m_sca);
        chk("hdr_flg", int'(hdr_flg), m_flg);
      end
      chk("err_seq", int'(err_seq), int'(m_eseq));
      chk("err_ovf", int'(err_ovf), int'(m_eovf));
      if (dout_we) c_we++;
      if (hdr_vld) c_hvld++;
      if (evt_done) begin
        c_done++;
        last_smp = int'(smpcnt);
        last_nodata = int'(evt_nodata);
      end

      // Advance the model across the coming rising edge
      seq = 0; ovf = 0; m_done = 0; m_hvld = 0; ch = 0;
      pre = mq.size();
      if (push) begin
        ch = from_gray(ado);
        if (ch != m_exp_ch) seq = 1;
        if (ch == 0) m_ovlp = !d14;
        if (ch == 15) begin
          if (d13) seq = 1;
          m_hvld = 1;
          m_l1p = int'(m_hdr[7:0]);
          m_sca = int'(m_hdr[11:8]);
          m_flg = int'({m_ovlp, m_hdr[14], m_hdr[13], m_hdr[12]});
        end else begin
          m_hdr[ch] = d13;
        end
        m_exp_ch = (ch + 1) % 16;
        if (ch == 15 && m_smp < 31) m_smp++;
      end
      if (rd) void'(mq.pop_front());
      if (push) begin
        chb = 4'(ch);
        if (pre < 4 || rd) mq.push_back({chb, din});
        else ovf = 1;
      end
      if (m_phase == 2) begin
        if (lastword) seq = 1;
        if (push) m_dpush = 1;
        if (pre == 0) begin
          m_done = 1; m_nodata = 0; m_smp_out = m_evt_smp;
          m_phase = m_dpush ? 1 : 0;
        end
      end else if (lastword) begin
        if (m_phase == 0 && !push) begin
          m_done = 1; m_nodata = 1; m_smp_out = 0;
        end else begin
          if (m_exp_ch != 0) seq = 1;
          m_evt_smp = m_smp; m_exp_ch = 0; m_smp = 0; m_phase = 2; m_dpush = 0;
        end
      end else if (push) begin
        m_phase = 1;
      end
      m_eseq = seq ? 1'b1 : (clr_err ? 1'b0 : m_eseq);
      m_eovf = ovf ? 1'b1 : (clr_err ? 1'b0 : m_eovf);
    end
  end

  // Header pattern: L1P=0xA5, SCA=0x9, l1a_phase=1
  logic [15:0] hdr_pat = 16'h19A5;
  logic        d14_ch0 = 1'b1;

  task automatic step(input bit p, input int ch, input int d, input bit last_i,
                      input bit full_i, input bit clr_i);
    push = p;
    ado = to_gray(ch);
    din = 12'(d);
    d13 = hdr_pat[ch];
    d14 = (ch == 0) ? d14_ch0 : 1'b1;
    lastword = last_i;
    wr_full = full_i;
    clr_err = clr_i;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit full_i);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, full_i, 0);
  endtask

  int b_we, b_hv, b_dn;

  task automatic snap();
    b_we = c_we; b_hv = c_hvld; b_dn = c_done;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_smpcnt", int'(smpcnt), 0);
    chk("reset_dout_we", int'(dout_we), 0);
    rst_b = 1'b1;
    idle(2, 0);

    // Nominal: two full samples then LASTWORD
    snap();
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 16; c++) step(1, c, s * 256 + c * 3, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(6, 0);
    chk("nom_dout_we_count", c_we - b_we, 32);
    chk("nom_hdr_vld_count", c_hvld - b_hv, 2);
    chk("nom_evt_done_count", c_done - b_dn, 1);
    chk("nom_smpcnt", last_smp, 2);
    chk("nom_nodata", last_nodata, 0);
    chk("nom_l1p", int'(hdr_l1p), 'hA5);
    chk("nom_sca", int'(hdr_sca), 'h9);
    chk("nom_flg", int'(hdr_flg), 'h1);
    chk("nom_err_seq", int'(err_seq), 0);

    // No-data event
    snap();
    step(0, 0, 0, 1, 0, 0);
    chk("nd_done_next_cycle", int'(evt_done), 1);
    chk("nd_nodata", int'(evt_nodata), 1);
    chk("nd_smpcnt", int'(smpcnt), 0);
    idle(3, 0);
    chk("nd_done_count", c_done - b_dn, 1);
    chk("nd_no_dout_we", c_we - b_we, 0);

    // Backpressure with overflow
    snap();
    for (int c = 0; c < 6; c++) step(1, c, 'h500 + c, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("bp_err_ovf", int'(err_ovf), 1);
    chk("bp_no_write_while_full", c_we - b_we, 0);
    idle(6, 0);
    chk("bp_retained_words", c_we - b_we, 4);
    step(0, 0, 0, 1, 0, 0);
    idle(4, 0);
    chk("bp_evt_done_count", c_done - b_dn, 1);
    chk("bp_smpcnt", last_smp, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("bp_clr_ovf", int'(err_ovf), 0);
    chk("bp_clr_seq", int'(err_seq), 0);

    // Sequence error: channel 3 -> 5
    snap();
    for (int c = 0; c < 4; c++) step(1, c, 'h300 + c, 0, 0, 0);
    step(1, 5, 'h305, 0, 0, 0);
    chk("seq_err_set", int'(err_seq), 1);
    step(1, 6, 'h306, 0, 0, 1);
    chk("seq_next_exp_6_and_clr", int'(err_seq), 0);
    for (int c = 7; c < 16; c++) step(1, c, 'h300 + c, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(6, 0);
    chk("seq_dout_we_count", c_we - b_we, 15);
    chk("seq_smpcnt", last_smp, 1);
    chk("seq_clean_after", int'(err_seq), 0);
    step(1, 3, 'h7, 0, 0, 1);
    chk("seq_error_beats_clr", int'(err_seq), 1);
    step(0, 0, 0, 1, 0, 0);
    idle(5, 0);
    step(0, 0, 0, 0, 0, 1);

    // PUSH and LASTWORD together on channel 15, overlap flagged
    snap();
    d14_ch0 = 1'b0;
    for (int c = 0; c < 15; c++) step(1, c, 'h600 + c, 0, 0, 0);
    step(1, 15, 'h60F, 1, 0, 0);
    d14_ch0 = 1'b1;
    idle(6, 0);
    chk("cl_dout_we_count", c_we - b_we, 16);
    chk("cl_evt_done_count", c_done - b_dn, 1);
    chk("cl_smpcnt", last_smp, 1);
    chk("cl_flg_ovlp", int'(hdr_flg), 'h9);
    chk("cl_err_seq", int'(err_seq), 0);

    // Reset while draining
    snap();
    for (int c = 0; c < 4; c++) step(1, c, 'h700 + c, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    rst_b = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    chk("rd_dout_we_in_reset", int'(dout_we), 0);
    idle(2, 0);
    rst_b = 1'b1;
    idle(6, 0);
    chk("rd_no_evt_done", c_done - b_dn, 0);
    chk("rd_no_dout_we", c_we - b_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
